// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
// md_pkg : shared encodings and default latencies for the multiply/divide unit
// Revision: 1.0
// ============================================================================
package md_pkg;

  localparam logic [1:0] MD_MULTU = 2'b00;
  localparam logic [1:0] MD_DIVU  = 2'b01;
  localparam logic [1:0] MD_MULT  = 2'b10;
  localparam logic [1:0] MD_DIV   = 2'b11;

  localparam logic [1:0] MF_LO = 2'b01;
  localparam logic [1:0] MF_HI = 2'b10;

  localparam int DEF_MULT_LAT = 5;
  localparam int DEF_DIV_LAT  = 10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

endpackage
`default_nettype wire

// File: rtl/md_core.sv
`default_nettype none
// ============================================================================
// md_core : combinational multiply(-accumulate) and divide datapath
// Revision: 1.0
// ============================================================================
module md_core
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       op,
  input  logic             msub,
  input  logic             madd,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  output logic [WIDTH-1:0] ph,
  output logic [WIDTH-1:0] pl,
  output logic             div_by_zero
);

  localparam int W2 = 2 * WIDTH;

  logic             is_signed;
  logic             is_div;
  logic [W2-1:0]    a_ext;
  logic [W2-1:0]    b_ext;
  logic [W2-1:0]    prod;
  logic [W2-1:0]    mac;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] b_safe;
  logic [WIDTH-1:0] uq;
  logic [WIDTH-1:0] ur;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;

  always_comb begin
    is_signed = op[1];
    is_div    = op[0];

    // The low 2*WIDTH bits of a product of extended operands are exact for
    // both signed and unsigned interpretations.
    a_ext = is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    b_ext = is_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    prod  = a_ext * b_ext;

    mac = prod;
    if (op == MD_MULT) begin
      if (msub) begin
        mac = {acc_hi, acc_lo} - prod;
      end else if (madd) begin
        mac = {acc_hi, acc_lo} + prod;
      end
    end

    // Sign-magnitude divide; most-negative / -1 wraps back to the dividend.
    a_neg  = is_signed & a[WIDTH-1];
    b_neg  = is_signed & b[WIDTH-1];
    a_mag  = a_neg ? -a : a;
    b_mag  = b_neg ? -b : b;
    b_safe = (b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    uq     = a_mag / b_safe;
    ur     = a_mag % b_safe;
    q      = (a_neg ^ b_neg) ? -uq : uq;
    r      = a_neg ? -ur : ur;

    div_by_zero = is_div & (b == '0);

    if (is_div) begin
      ph = r;
      pl = q;
    end else begin
      ph = mac[W2-1:WIDTH];
      pl = mac[WIDTH-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// md_unit : EX-stage multiply/divide unit owning the HI/LO registers
// Revision: 1.0
// ============================================================================
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       MDop,
  input  logic             ifmsub,
  input  logic             ifmadd,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic             cancel,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       mf,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] mfout
);

  localparam int LAT_MAX = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] ph_q, ph_d;
  logic [WIDTH-1:0] pl_q, pl_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0] core_ph;
  logic [WIDTH-1:0] core_pl;
  logic             core_dbz;

  // HI/LO cannot change while busy, so the result is captured at the start edge.
  md_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op          (MDop),
    .msub        (ifmsub),
    .madd        (ifmadd),
    .a           (A),
    .b           (B),
    .acc_hi      (hi_q),
    .acc_lo      (lo_q),
    .ph          (core_ph),
    .pl          (core_pl),
    .div_by_zero (core_dbz)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    pl_d    = pl_q;
    dbz_d   = dbz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else if (start) begin
          ph_d    = core_ph;
          pl_d    = core_pl;
          dbz_d   = core_dbz;
          cnt_d   = MDop[0] ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
          state_d = ST_RUN;
        end else begin
          if (mthi) hi_d = A;
          if (mtlo) lo_d = A;
        end
      end
      ST_RUN: begin
        if (cancel) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_IDLE;
            if (!dbz_q) begin
              hi_d = ph_q;
              lo_d = pl_q;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ph_q    <= '0;
      pl_q    <= '0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      pl_q    <= pl_d;
      dbz_q   <= dbz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    case (mf)
      MF_LO:   mfout = lo_q;
      MF_HI:   mfout = hi_q;
      default: mfout = '0;
    endcase
  end

  assign busy = (state_q == ST_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// tb_md_unit : directed scoreboard bench for md_unit (default parameters)
// Revision: 1.0
// ============================================================================
module tb_md_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, ifmsub, ifmadd, mthi, mtlo, cancel;
  logic [1:0]  MDop, mf;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] HI, LO, mfout;

  always #5 clk = ~clk;

  md_unit dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .MDop   (MDop),
    .ifmsub (ifmsub),
    .ifmadd (ifmadd),
    .mthi   (mthi),
    .mtlo   (mtlo),
    .cancel (cancel),
    .A      (A),
    .B      (B),
    .mf     (mf),
    .busy   (busy),
    .HI     (HI),
    .LO     (LO),
    .mfout  (mfout)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          blen;
    int          tag;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] op, input logic ms, input logic ma,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el,
                        input int bl, input int tag);
    exp_t e;
    e.hi = eh; e.lo = el; e.blen = bl; e.tag = tag;
    sb.push_back(e);
    MDop = op; ifmsub = ms; ifmadd = ma; A = a; B = b; start = 1'b1;
    tick();
    start = 1'b0; ifmsub = 1'b0; ifmadd = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    total++;
    if (busy) begin
      bad++;
      $display("FAIL %s timeout: busy=%b want 0", name, busy);
    end
    tick();
  endtask

  // Monitor: each falling edge of busy retires one scoreboard entry.
  initial begin : monitor
    int   blen;
    logic prev;
    exp_t e;
    blen = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (busy) begin
        blen++;
      end else if (prev) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_retire: HI=%h LO=%h with empty scoreboard", HI, LO);
        end else begin
          e = sb.pop_front();
          chk($sformatf("op%0d_hi", e.tag), HI, e.hi);
          chk($sformatf("op%0d_lo", e.tag), LO, e.lo);
          chk($sformatf("op%0d_busy_len", e.tag), 32'(blen), 32'(e.blen));
        end
        blen = 0;
      end
      prev = busy;
    end
  end

  initial begin
    reset = 1'b0; start = 1'b0; ifmsub = 1'b0; ifmadd = 1'b0;
    mthi = 1'b0; mtlo = 1'b0; cancel = 1'b0;
    MDop = MD_MULTU; mf = MF_LO; A = '0; B = '0;
    tick(); tick();
    chk("reset_hi", HI, 32'h0);
    chk("reset_lo", LO, 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    reset = 1'b1;
    tick();

    launch(MD_MULTU, 0, 0, 32'hFFFF_FFFF, 32'd2, 32'h1, 32'hFFFF_FFFE, 5, 1);
    wait_idle("multu");
    mf = MF_LO; #1 chk("mf_lo", mfout, 32'hFFFF_FFFE);
    mf = MF_HI; #1 chk("mf_hi", mfout, 32'h1);
    mf = 2'b11; #1 chk("mf_other", mfout, 32'h0);

    launch(MD_MULT, 0, 0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5, 2);
    wait_idle("mult");
    launch(MD_MULT, 1, 0, 32'd2, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFE1, 5, 3);
    wait_idle("msub");
    launch(MD_MULT, 0, 1, 32'd1, 32'd31, 32'h0, 32'h0, 5, 4);
    wait_idle("madd");
    launch(MD_MULT, 1, 1, 32'd2, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, 5);
    wait_idle("msub_madd");

    launch(MD_DIV, 0, 0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 6);
    wait_idle("div_neg");
    launch(MD_DIV, 0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 10, 7);
    wait_idle("div_ovf");
    launch(MD_DIVU, 0, 0, 32'd5, 32'd0, 32'h0, 32'h8000_0000, 10, 8);
    wait_idle("divu_zero");
    launch(MD_DIVU, 0, 0, 32'd100, 32'd7, 32'd2, 32'd14, 10, 9);
    wait_idle("divu");

    // Cancel during busy cycle 4.
    launch(MD_DIV, 0, 0, 32'd20, 32'd3, 32'd2, 32'd14, 4, 10);
    tick(); tick(); tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel_busy", 32'(busy), 32'h0);
    tick();
    launch(MD_DIV, 0, 0, 32'd21, 32'hFFFF_FFFC, 32'd1, 32'hFFFF_FFFB, 10, 11);
    wait_idle("div_after_cancel");

    // mthi while busy is ignored.
    launch(MD_MULTU, 0, 0, 32'd6, 32'd7, 32'h0, 32'h2A, 5, 12);
    A = 32'h1234; mthi = 1'b1;
    tick();
    mthi = 1'b0;
    wait_idle("mthi_busy");

    A = 32'hAA; mthi = 1'b1; mtlo = 1'b1;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    chk("mthilo_hi", HI, 32'hAA);
    chk("mthilo_lo", LO, 32'hAA);

    // mthi with start: start wins.
    mthi = 1'b1;
    launch(MD_MULTU, 0, 0, 32'h10, 32'h10, 32'h0, 32'h100, 5, 13);
    mthi = 1'b0;
    chk("mthi_start_hi", HI, 32'hAA);
    wait_idle("mthi_start");

    A = 32'd5; mtlo = 1'b1; cancel = 1'b1;
    tick();
    mtlo = 1'b0; cancel = 1'b0;
    chk("cancel_mtlo", LO, 32'h100);

    MDop = MD_MULTU; A = 32'd9; B = 32'd9; start = 1'b1; cancel = 1'b1;
    tick();
    start = 1'b0; cancel = 1'b0;
    chk("cancel_start_busy", 32'(busy), 32'h0);
    tick();
    chk("cancel_start_busy2", 32'(busy), 32'h0);

    // Cancel coincident with the commit edge.
    launch(MD_MULTU, 0, 0, 32'd2, 32'd3, 32'h0, 32'h100, 5, 14);
    tick(); tick(); tick(); tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    tick();

    // Asynchronous reset mid-divide.
    launch(MD_DIV, 0, 0, 32'd9, 32'd2, 32'h0, 32'h0, 2, 15);
    tick(); tick();
    #1 reset = 1'b0;
    #1;
    chk("areset_busy", 32'(busy), 32'h0);
    chk("areset_hi", HI, 32'h0);
    chk("areset_lo", LO, 32'h0);
    tick();
    reset = 1'b1;
    tick();

    // Second start while busy is ignored.
    launch(MD_MULTU, 0, 0, 32'd3, 32'd4, 32'h0, 32'hC, 5, 16);
    MDop = MD_MULT; A = 32'd5; B = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle("start_busy");
    tick(); tick(); tick();
    chk("final_busy", 32'(busy), 32'h0);
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multiply/divide unit that sits in the EX stage next to the ALU.
- Consumes the decoder's start, MDop, ifmsub, mthi and mtlo strobes, and owns the HI/LO architectural registers.
- Adds configurable operand width, separate multiply/divide latencies, msub/madd accumulate, cancel on exception, and a busy handshake for the hazard unit.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_LAT, 5, busy cycles for mult/multu/msub/madd (must be at least 1).
- DIV_LAT, 10, busy cycles for div/divu (must be at least 1).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  launch operation; sampled only when busy=0
- MDop  input  2  00 multu, 01 divu, 10 mult, 11 div
- ifmsub  input  1  with start and MDop=10: {HI,LO} -= A*B (signed)
- ifmadd  input  1  with start and MDop=10: {HI,LO} += A*B (signed)
- mthi  input  1  write A to HI
- mtlo  input  1  write A to LO
- cancel  input  1  exception/eret flush; kill the in-flight operation
- A  input  WIDTH  rs operand
- B  input  WIDTH  rt operand
- mf  input  2  read select: 01 LO, 10 HI, others 0
- busy  output  1  operation in flight
- HI  output  WIDTH  HI register
- LO  output  WIDTH  LO register
- mfout  output  WIDTH  mf-selected value (combinational from HI/LO)

Behaviour:
- Reset (reset=0, asynchronous): HI=0, LO=0, busy=0, counter=0, pending result cleared.
- Launch:
  - start=1 and busy=0 at a clock edge: operands are latched; the counter is loaded with MULT_LAT or DIV_LAT; busy=1 from the next cycle.
  - The result is computed from the latched operands into pending {PH,PL}. Internal pipelining or a single-cycle compute are both acceptable; only commit timing is visible.
- Countdown and commit:
  - While busy, the counter decrements every cycle.
  - On the edge where the counter goes 1 to 0: HI<=PH, LO<=PL, busy<=0.
  - Total latency: new HI/LO are visible exactly LAT cycles after the start edge, the same cycle busy falls.
- start while busy=1: ignored; the hazard unit must stall. No queueing.
- mthi/mtlo:
  - Honoured only when busy=0 and start=0. HI or LO takes A on that edge.
  - If asserted with start on the same edge, start wins and mthi/mtlo is dropped.
  - mthi and mtlo asserted together: both are written (HI=A, LO=A).
- Arithmetic rules:
  - multu: {HI,LO} = zext(A)*zext(B), 2*WIDTH bits.
  - mult: signed product.
  - msub/madd: {HI,LO} current at the start edge ∓/± signed A*B, modulo 2^(2*WIDTH). ifmsub and ifmadd together: treat as msub.
  - divu: LO = A/B, HI = A%B, unsigned.
  - div: truncating quotient; remainder takes the dividend's sign.
  - div with A=most-negative and B=-1: LO=A, HI=0.
  - B=0 (div or divu): the op runs the full DIV_LAT with busy asserted, but HI/LO are left unchanged at commit.
- Cancel:
  - cancel=1 at any edge while busy: counter cleared, busy<=0 next cycle, HI/LO unchanged.
  - cancel coincident with the final commit edge: the commit is suppressed.
  - cancel with start on the same edge: start is ignored.
  - cancel with mthi/mtlo on the same edge: the write is suppressed.
- mfout during busy: returns the old HI/LO. The hazard unit stalls mf* while busy.
- Reset asserted mid-operation: everything clears immediately; no commit.

Decomposition:
- Shared package md_pkg:
  - MDop encodings MD_MULTU, MD_DIVU, MD_MULT, MD_DIV.
  - mf encodings MF_LO, MF_HI.
  - Default latency constants.
- One natural sub-module: md_core.
  - Combinational/parametric signed/unsigned multiply-accumulate and divide datapath producing {PH,PL} plus a div_by_zero flag.
  - md_unit keeps the counter, the busy FSM (IDLE/RUN) and the HI/LO registers.

Test Plan:
- multu, A=0xFFFFFFFF, B=2 -> busy high exactly 5 cycles; then HI=0x00000001, LO=0xFFFFFFFE.
- mult A=-3, B=7, then msub A=2, B=5 -> after msub, {HI,LO} = -31 (HI=0xFFFFFFFF, LO=0xFFFFFFE1). madd A=1, B=31 afterwards -> HI=0, LO=0.
- div A=-7, B=2 -> after 10 cycles LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). div A=0x80000000, B=-1 -> LO=0x80000000, HI=0. divu A=5, B=0 -> busy for 10 cycles, HI/LO unchanged.
- Start div, pulse cancel on busy cycle 4 -> busy=0 next cycle, HI/LO keep their prior values; a new start then commits normally.
- mthi A=0x1234 while busy -> ignored. mthi and mtlo together with A=0xAA while idle -> HI=LO=0xAA. mthi with start on the same edge -> HI comes from the op result only.
- Reset pulled low mid-divide -> HI=LO=0 and busy=0 immediately (asynchronous); second start during busy -> ignored, single commit observed.
